// File: rtl/hash_tte_pkg.sv
// Shared widths, FSM encodings and the captured search key for the TTE hash search-port arbiter.
package hash_tte_pkg;
    localparam int MAC_W       = 48;
    localparam int HASH_W      = 12;
    localparam int PMAP_W      = 16;
    localparam int NPORT_DEF   = 4;
    localparam int TIMEOUT_DEF = 8192;
    localparam int DRAIN_DEF   = 8;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_RESP  = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

    typedef struct packed {
        logic [MAC_W-1:0]  dmac;
        logic [MAC_W-1:0]  smac;
        logic [HASH_W-1:0] hash;
    } se_key_t;
endpackage

// File: rtl/hash_tte_se_arbiter_if.sv
// Requester-side and bucket-side signals of the search-port arbiter.
interface hash_tte_se_arbiter_if
    import hash_tte_pkg::*;
#(
    parameter int NPORT = NPORT_DEF
);
    logic [NPORT-1:0]        port_req;
    logic [NPORT*MAC_W-1:0]  port_dmac;
    logic [NPORT*MAC_W-1:0]  port_smac;
    logic [NPORT*HASH_W-1:0] port_hash;
    logic [NPORT-1:0]        port_ack;
    logic [NPORT-1:0]        port_nak;
    logic [PMAP_W-1:0]       port_result;
    logic                    port_tmo;
    logic                    se_req;
    logic [MAC_W-1:0]        se_dmac;
    logic [MAC_W-1:0]        se_smac;
    logic [HASH_W-1:0]       se_hash;
    logic                    se_ack;
    logic                    se_nak;
    logic [PMAP_W-1:0]       se_result;
    logic                    err_stray;

    modport slave (
        input  port_req, port_dmac, port_smac, port_hash, se_ack, se_nak, se_result,
        output port_ack, port_nak, port_result, port_tmo, se_req, se_dmac, se_smac, se_hash,
               err_stray
    );

    modport master (
        output port_req, port_dmac, port_smac, port_hash, se_ack, se_nak, se_result,
        input  port_ack, port_nak, port_result, port_tmo, se_req, se_dmac, se_smac, se_hash,
               err_stray
    );
endinterface

// File: rtl/rr_arb_n.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping.
module rr_arb_n #(
    parameter int N  = 4,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [PW-1:0] idx,
    output logic          any
);
    always_comb begin
        int j;
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        j     = 0;
        for (int i = 0; i < N; i++) begin
            j = (int'(ptr) + i) % N;
            if (!any && req[j]) begin
                any      = 1'b1;
                grant[j] = 1'b1;
                idx      = PW'(j);
            end
        end
    end
endmodule

// File: rtl/hash_tte_se_arbiter.sv
// Shares the single hash-bucket search port among NPORT requesters, one search in flight,
// bounded by a response timeout and a post-timeout drain window.
module hash_tte_se_arbiter
    import hash_tte_pkg::*;
#(
    parameter int NPORT   = NPORT_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF,
    parameter int DRAIN   = DRAIN_DEF
) (
    input logic                  clk,
    input logic                  rst,
    hash_tte_se_arbiter_if.slave bus
);
    localparam int PW = (NPORT > 1) ? $clog2(NPORT) : 1;
    localparam int TW = $clog2(TIMEOUT) + 1;

    logic [1:0]       state;
    logic [PW-1:0]    ptr;
    logic [PW-1:0]    ptr_nxt;
    logic [TW-1:0]    timer;
    logic [NPORT-1:0] cur_oh;
    logic [NPORT-1:0] gnt_oh;
    logic [PW-1:0]    gnt_idx;
    logic             gnt_any;
    se_key_t          key_sel;

    rr_arb_n #(.N(NPORT), .PW(PW)) u_rr (
        .req   (bus.port_req),
        .ptr   (ptr),
        .grant (gnt_oh),
        .idx   (gnt_idx),
        .any   (gnt_any)
    );

    always_comb begin
        key_sel.dmac = bus.port_dmac[int'(gnt_idx)*MAC_W +: MAC_W];
        key_sel.smac = bus.port_smac[int'(gnt_idx)*MAC_W +: MAC_W];
        key_sel.hash = bus.port_hash[int'(gnt_idx)*HASH_W +: HASH_W];
    end

    assign ptr_nxt = (gnt_idx == PW'(NPORT-1)) ? '0 : gnt_idx + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= ST_IDLE;
            ptr             <= '0;
            timer           <= '0;
            cur_oh          <= '0;
            bus.port_ack    <= '0;
            bus.port_nak    <= '0;
            bus.port_result <= '0;
            bus.port_tmo    <= 1'b0;
            bus.se_req      <= 1'b0;
            bus.se_dmac     <= '0;
            bus.se_smac     <= '0;
            bus.se_hash     <= '0;
            bus.err_stray   <= 1'b0;
        end else begin
            bus.port_ack  <= '0;
            bus.port_nak  <= '0;
            bus.port_tmo  <= 1'b0;
            bus.err_stray <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.se_ack || bus.se_nak) bus.err_stray <= 1'b1;
                    if (gnt_any) begin
                        bus.se_dmac <= key_sel.dmac;
                        bus.se_smac <= key_sel.smac;
                        bus.se_hash <= key_sel.hash;
                        bus.se_req  <= 1'b1;
                        cur_oh      <= gnt_oh;
                        ptr         <= ptr_nxt;
                        timer       <= '0;
                        state       <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    timer <= timer + 1'b1;
                    // ack wins when the bucket raises both in the same cycle
                    if (bus.se_ack) begin
                        bus.port_ack    <= cur_oh;
                        bus.port_result <= bus.se_result;
                        bus.se_req      <= 1'b0;
                        state           <= ST_RESP;
                    end else if (bus.se_nak) begin
                        bus.port_nak <= cur_oh;
                        bus.se_req   <= 1'b0;
                        state        <= ST_RESP;
                    end else if (timer == TW'(TIMEOUT-1)) begin
                        bus.port_nak <= cur_oh;
                        bus.port_tmo <= 1'b1;
                        bus.se_req   <= 1'b0;
                        timer        <= '0;
                        state        <= ST_DRAIN;
                    end
                end
                ST_RESP: begin
                    if (bus.se_ack || bus.se_nak) bus.err_stray <= 1'b1;
                    state <= ST_IDLE;
                end
                ST_DRAIN: begin
                    // late bucket answers to the abandoned search land here and are dropped
                    timer <= timer + 1'b1;
                    if (timer == TW'(DRAIN-1)) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule
